adder_req_ctrl: RTL and testbench
=================================

// Module: adder_req_ctrl
// PURPOSE
//  Requester side of the adder_if protocol: accepts operand pairs on a valid/ready
//  input channel and drives adder_a/adder_b/adder_cin into the combinational adder.
//  Holds the operands for SETTLE_CYC cycles, then captures adder_sum/adder_cout.
//  Returns the result on a valid/ready output channel.
//  Optional carry chaining supports multi-word additions.
// PARAMETERS
//  N_BIT       32  operand/sum width; matches adder_if N_BIT
//  N_BPB        4  adder bits-per-block; informational only, no effect on logic
//  SETTLE_CYC   2  cycles operands are held before sampling the adder (>=1)
//  CNT_W       16  width of op_count
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst         in   1      synchronous reset, active high
//  in_valid    in   1      operand request valid
//  in_ready    out  1      controller can accept a request
//  in_a        in   N_BIT  operand A
//  in_b        in   N_BIT  operand B
//  in_cin      in   1      carry-in, used when in_chain=0
//  in_chain    in   1      1: carry-in = cout of previous captured result
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_sum     out  N_BIT  captured sum
//  out_cout    out  1      captured carry-out
//  adder_a     out  N_BIT  to adder_if.adder_a
//  adder_b     out  N_BIT  to adder_if.adder_b
//  adder_cin   out  1      to adder_if.adder_cin
//  adder_sum   in   N_BIT  from adder_if.adder_sum
//  adder_cout  in   1      from adder_if.adder_cout
//  busy        out  1      state != IDLE
//  op_count    out  CNT_W  completed output handshakes, wraps at 2^CNT_W
// BEHAVIOUR
//  Clock and reset are decided: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE; in_ready=1 in IDLE; out_valid=0; out_sum=0; out_cout=0.
//   Also adder_a=0, adder_b=0, adder_cin=0, carry_q=0, op_count=0, busy=0.
//  Reset wins over every other event, including mid-SETTLE or in RESULT.
//   Any in-flight operation is discarded and no out_valid is produced.
//  States: IDLE, SETTLE, RESULT.
//  Accept condition: in_valid & in_ready.
//   in_ready = (state==IDLE) | (state==RESULT & out_ready).
//  On accept: adder_a<=in_a, adder_b<=in_b, adder_cin<=(in_chain ? carry_q : in_cin).
//   Settle counter loaded with SETTLE_CYC-1; next state SETTLE.
//  SETTLE: counter decrements each cycle. On the edge where counter==0:
//   out_sum<=adder_sum, out_cout<=adder_cout, carry_q<=adder_cout; next state RESULT.
//  Latency: accept at edge E0 -> out_valid high after edge E0+SETTLE_CYC.
//  RESULT: out_valid=1. out_sum and out_cout stay stable until out_ready=1.
//   out_ready=1: op_count++ (modulo 2^CNT_W).
//    If a request is accepted on the same edge -> SETTLE, else -> IDLE.
//  adder_a/b/cin only change on accept or reset; they hold last values in IDLE.
//  in_valid in SETTLE, or in RESULT with out_ready=0, is ignored: not captured.
//  Width rules: sum is N_BIT, modulo 2^N_BIT; overflow is reported only via cout.
//  in_chain=1 on the first op after reset uses carry_q=0.
// TESTING  (N_BIT=32, SETTLE_CYC=2)
//  Reset held 3 cycles -> all outputs 0, in_ready=1, busy=0, op_count=0.
//  5+3, cin=0, accept at E0 -> out_valid after E2, out_sum=0x00000008, out_cout=0.
//  0xFFFFFFFF+0x00000001, cin=0 -> sum=0x00000000, cout=1.
//   Then 0+0 with in_chain=1 -> sum=0x00000001, cout=0.
//  out_ready=0 for 5 cycles in RESULT with in_valid=1 -> in_ready=0, outputs stable.
//   Then out_ready=1 -> op_count=1, new op accepted on that same edge.
//  Back-to-back: 0x10+0x20 then 0x7FFFFFFF+0x1, out_ready=1 -> results 0x30 then 0x80000000.
//   Second accept lands on the first result's handshake edge; op_count=2.
//  rst=1 during SETTLE -> next cycle IDLE, out_valid never asserted.
//   carry_q=0, so a following in_chain=1 op uses cin=0.

Source files
------------

// File: rtl/adder_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_req_ctrl
// Brief    : Requester for a combinational adder: takes operands over a
//            valid/ready channel, holds them to settle, returns sum/carry.
// Revision : 1.0
// ============================================================================
module adder_req_ctrl #(
    parameter int N_BIT      = 32,
    parameter int N_BPB      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_BIT-1:0] in_a,
    input  logic [N_BIT-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] out_sum,
    output logic             out_cout,
    output logic [N_BIT-1:0] adder_a,
    output logic [N_BIT-1:0] adder_b,
    output logic             adder_cin,
    input  logic [N_BIT-1:0] adder_sum,
    input  logic             adder_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int C_SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [C_SCNT_W-1:0] C_SCNT_LOAD = C_SCNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [C_SCNT_W-1:0] settle_cnt;
    logic                carry_q;
    logic                accept;
    logic                settle_done;

    assign in_ready    = (state == IDLE) || ((state == RESULT) && out_ready);
    assign accept      = in_valid && in_ready;
    assign settle_done = (state == SETTLE) && (settle_cnt == '0);
    assign out_valid   = (state == RESULT);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_done) state_nxt = RESULT;
            end
            RESULT: begin
                if (out_ready) state_nxt = accept ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand hold registers only move on accept so the adder sees stable inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            adder_a    <= '0;
            adder_b    <= '0;
            adder_cin  <= 1'b0;
            settle_cnt <= '0;
            carry_q    <= 1'b0;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                adder_a    <= in_a;
                adder_b    <= in_b;
                adder_cin  <= in_chain ? carry_q : in_cin;
                settle_cnt <= C_SCNT_LOAD;
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (settle_done) begin
                out_sum  <= adder_sum;
                out_cout <= adder_cout;
                carry_q  <= adder_cout;
            end

            if ((state == RESULT) && out_ready) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_req_ctrl
// Brief    : Directed + random bench for adder_req_ctrl with a behavioural adder.
// Revision : 1.0
// ============================================================================
module tb_adder_req_ctrl;

    localparam int N  = 32;
    localparam int S  = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          in_cin;
    logic          in_chain;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic          out_cout;
    logic [N-1:0]  adder_a;
    logic [N-1:0]  adder_b;
    logic          adder_cin;
    logic [N-1:0]  adder_sum;
    logic          adder_cout;
    logic          busy;
    logic [CW-1:0] op_count;

    adder_req_ctrl #(.N_BIT(N), .N_BPB(4), .SETTLE_CYC(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout),
        .busy(busy), .op_count(op_count)
    );

    // Stand-in for the combinational adder on the other side of adder_if.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{N{1'b0}}, adder_cin};

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic          model_carry;
    logic [CW-1:0] exp_cnt;
    logic [N-1:0]  exp_sum;
    logic          exp_cout;
    logic          exp_cin;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a request and predict its result from the transaction history.
    task automatic present(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin, input logic chain);
        logic [N:0] full;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_chain = chain;
        exp_cin  = chain ? model_carry : cin;
        full     = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, exp_cin};
        exp_sum  = full[N-1:0];
        exp_cout = full[N];
    endtask

    task automatic after_accept(input string tag);
        in_valid = 1'b0;
        check({tag, "_adder_a"}, 64'(adder_a), 64'(in_a));
        check({tag, "_adder_cin"}, 64'(adder_cin), 64'(exp_cin));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        for (int k = 1; k < S; k++) begin
            tick;
            check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        end
        tick;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!out_valid && n < 8) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
        model_carry = exp_cout;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        exp_cnt++;
        check({tag, "_op_count"}, 64'(op_count), 64'(exp_cnt));
    endtask

    task automatic full_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin, input logic chain);
        present(a, b, cin, chain);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick;
        after_accept(tag);
        wait_result(tag);
        handshake(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick;
        rst = 1'b0;
        model_carry = 1'b0;
        exp_cnt     = '0;
    endtask

    initial begin
        logic [N-1:0] held_sum;
        logic         held_cout;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_chain  = 1'b0;
        out_ready = 1'b0;

        do_reset(3);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_adder", 64'({adder_a, adder_b[0], adder_cin}), 64'd0);

        full_op("add5p3", 32'd5, 32'd3, 1'b0, 1'b0);
        full_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        full_op("chain", 32'h0, 32'h0, 1'b0, 1'b1);
        check("idle_hold_adder_a", 64'(adder_a), 64'd0);

        // Result held under back-pressure while a new request waits.
        present(32'hABCD_0000, 32'h1234, 1'b1, 1'b0);
        tick;
        after_accept("stall_first");
        wait_result("stall_first");
        held_sum  = out_sum;
        held_cout = out_cout;
        present(32'h0000_00F0, 32'h0F, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'({out_cout, out_sum}), 64'({held_cout, held_sum}));
            tick;
        end
        check("stall_no_capture", 64'(adder_a), 64'hABCD_0000);
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", 64'(in_ready), 64'd1);
        tick;
        out_ready = 1'b0;
        exp_cnt++;
        check("stall_op_count", 64'(op_count), 64'(exp_cnt));
        check("stall_same_edge_valid", 64'(out_valid), 64'd0);
        after_accept("stall_second");
        wait_result("stall_second");
        handshake("stall_second");

        // Back-to-back: second accept on the first result's handshake edge.
        present(32'h10, 32'h20, 1'b0, 1'b0);
        tick;
        after_accept("b2b_first");
        wait_result("b2b_first");
        present(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        tick;
        out_ready = 1'b0;
        exp_cnt++;
        check("b2b_op_count", 64'(op_count), 64'(exp_cnt));
        after_accept("b2b_second");
        wait_result("b2b_second");
        check("b2b_sum_const", 64'(out_sum), 64'h8000_0000);
        handshake("b2b_second");

        // Reset mid-SETTLE after leaving carry_q=1.
        full_op("carry_set", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        present(32'h55, 32'h66, 1'b0, 1'b0);
        tick;
        in_valid = 1'b0;
        do_reset(1);
        check("rst_settle_busy", 64'(busy), 64'd0);
        check("rst_settle_adder_a", 64'(adder_a), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("rst_settle_no_valid", 64'(out_valid), 64'd0);
            tick;
        end
        full_op("chain_after_rst", 32'h0, 32'h0, 1'b1, 1'b1);

        for (int i = 0; i < 16; i++) begin
            present($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick;
            after_accept("rand");
            wait_result("rand");
            repeat ($urandom_range(0, 3)) begin
                tick;
                check("rand_stall_sum", 64'(out_sum), 64'(exp_sum));
            end
            handshake("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
